// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests and buffers returned words.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module if_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [63:0] a_out,
    output logic        flush_out,
    output logic        fetch_fault
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(BUF_DEPTH);

    logic [63:0]   r_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_aq_wr;
    logic [PW-1:0] r_aq_rd;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_flush;
    logic [63:0]   r_aq_addr   [BUF_DEPTH];
    logic [63:0]   r_fifo_addr [BUF_DEPTH];
    logic [31:0]   r_fifo_inst [BUF_DEPTH];

    logic [CW:0]   w_in_use;
    logic          w_credit_ok;
    logic          w_halt;
    logic          w_req_fire;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic [63:0]   w_redirect_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_fault;

    // Every redirect re-evaluates alignment, so an aligned one clears the halt.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (redirect_valid) begin
            r_fault <= (redirect_pc[1:0] != 2'b00);
        end
    end

    assign w_redirect_pc = redirect_pc;
    assign w_halt        = r_fault;
    assign fetch_fault   = r_fault;
`else
    assign w_redirect_pc = redirect_pc & ~64'h3;
    assign w_halt        = 1'b0;
    assign fetch_fault   = 1'b0;
`endif

    // Credits come from registered counts only, so a pop frees a slot one cycle later.
    assign w_in_use       = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_credit_ok    = (w_in_use < DEPTH_C);
    assign imem_req_valid = !reset && !redirect_valid && !w_halt && w_credit_ok;
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_drop = imem_rsp_valid && (redirect_valid || (r_drop_cnt != '0));
    assign w_push = imem_rsp_valid && !w_drop;

    assign inst_valid = !reset && (r_count != '0);
    assign w_pop      = inst_valid && !stall && !redirect_valid;
    assign inst_out   = inst_valid ? r_fifo_inst[r_rd_ptr] : 32'h0;
    assign a_out      = inst_valid ? r_fifo_addr[r_rd_ptr] : 64'h0;
    assign flush_out  = r_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_aq_wr       <= '0;
            r_aq_rd       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_flush       <= 1'b0;
        end else begin
            r_flush <= redirect_valid;
            case ({w_req_fire, imem_rsp_valid})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: ;
            endcase
            if (redirect_valid) begin
                // Everything still in flight, minus a response landing right now, is stale.
                r_pc       <= w_redirect_pc;
                r_drop_cnt <= r_outstanding - CW'(imem_rsp_valid);
                r_count    <= '0;
                r_aq_wr    <= '0;
                r_aq_rd    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                if (w_req_fire) begin
                    r_pc    <= r_pc + 64'd4;
                    r_aq_wr <= r_aq_wr + PW'(1);
                end
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                    r_aq_rd  <= r_aq_rd + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and counts above.
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_aq_addr[r_aq_wr] <= r_pc;
        end
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= r_aq_addr[r_aq_rd];
            r_fifo_inst[r_wr_ptr] <= imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit (RESET_PC=0x1000, BUF_DEPTH=4) with a queue-based imem model.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [63:0] a_out;
    logic        flush_out;
    logic        fetch_fault;

    int n_checks = 0;
    int n_errors = 0;

    logic        mem_hold = 1'b0;
    logic [63:0] mem_q[$];
    logic [63:0] req_q[$];
    logic [63:0] pop_a_q[$];
    logic [31:0] pop_d_q[$];

    logic        s_req_valid, s_inst_valid, s_flush, s_fault;
    logic [63:0] s_req_addr, s_a_out;
    logic [31:0] s_inst_out;

    if_fetch_unit #(.RESET_PC(64'h1000), .BUF_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_out(inst_out), .a_out(a_out),
        .flush_out(flush_out), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0013;
    endfunction

    // One cycle: present the oldest pending memory response, sample outputs, log handshakes.
    task automatic cyc();
        if (!mem_hold && mem_q.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
        s_req_valid  = imem_req_valid;
        s_req_addr   = imem_req_addr;
        s_inst_valid = inst_valid;
        s_a_out      = a_out;
        s_inst_out   = inst_out;
        s_flush      = flush_out;
        s_fault      = fetch_fault;
        if (imem_req_valid && imem_req_ready) begin
            req_q.push_back(imem_req_addr);
            mem_q.push_back(imem_req_addr);
        end
        if (inst_valid && !stall && !redirect_valid) begin
            pop_a_q.push_back(a_out);
            pop_d_q.push_back(inst_out);
            $display("[%0t] pop a_out=%h inst_out=%h", $time, a_out, inst_out);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; mem_hold = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mem_q.delete(); req_q.delete(); pop_a_q.delete(); pop_d_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
        n_checks++; if (inst_valid !== 1'b0) begin n_errors++; $display("FAIL rst_inst_valid: got %b expected 0", inst_valid); end
        n_checks++; if (inst_out !== 32'h0) begin n_errors++; $display("FAIL rst_inst_out: got %h expected 0", inst_out); end
        n_checks++; if (a_out !== 64'h0) begin n_errors++; $display("FAIL rst_a_out: got %h expected 0", a_out); end
        n_checks++; if (flush_out !== 1'b0) begin n_errors++; $display("FAIL rst_flush: got %b expected 0", flush_out); end
        n_checks++; if (fetch_fault !== 1'b0) begin n_errors++; $display("FAIL rst_fault: got %b expected 0", fetch_fault); end
        reset = 1'b0;
        #1;
        n_checks++; if (imem_req_valid !== 1'b1) begin n_errors++; $display("FAIL rst_first_req: got %b expected 1", imem_req_valid); end
        n_checks++; if (imem_req_addr !== 64'h1000) begin n_errors++; $display("FAIL rst_first_addr: got %h expected 1000", imem_req_addr); end
    endtask

    task automatic test_stream();
        logic [63:0] got_a;
        logic [31:0] got_d;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            cyc();
            if (c >= 2) begin
                n_checks++; if (s_inst_valid !== 1'b1) begin n_errors++; $display("FAIL stream_valid_c%0d: got %b expected 1", c, s_inst_valid); end
            end
        end
        n_checks++; if (req_q.size() !== 12) begin n_errors++; $display("FAIL stream_req_count: got %0d expected 12", req_q.size()); end
        n_checks++; if (pop_a_q.size() !== 10) begin n_errors++; $display("FAIL stream_pop_count: got %0d expected 10", pop_a_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got_a = (i < req_q.size()) ? req_q[i] : '1;
            n_checks++; if (got_a !== 64'h1000 + 64'(4*i)) begin n_errors++; $display("FAIL stream_req_addr%0d: got %h expected %h", i, got_a, 64'h1000 + 64'(4*i)); end
            got_a = (i < pop_a_q.size()) ? pop_a_q[i] : '1;
            got_d = (i < pop_d_q.size()) ? pop_d_q[i] : '1;
            n_checks++; if (got_a !== 64'h1000 + 64'(4*i)) begin n_errors++; $display("FAIL stream_a_out%0d: got %h expected %h", i, got_a, 64'h1000 + 64'(4*i)); end
            n_checks++; if (got_d !== mem_word(64'h1000 + 64'(4*i))) begin n_errors++; $display("FAIL stream_inst%0d: got %h expected %h", i, got_d, mem_word(64'h1000 + 64'(4*i))); end
        end
    endtask

    task automatic test_stall();
        int n0;
        logic [63:0] got_a;
        logic [31:0] got_d;
        do_reset();
        repeat (6) cyc();
        n0 = req_q.size();
        n_checks++; if (n0 !== 6) begin n_errors++; $display("FAIL stall_prefill_reqs: got %0d expected 6", n0); end
        stall = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cyc();
            n_checks++; if (s_inst_valid !== 1'b1) begin n_errors++; $display("FAIL stall_valid%0d: got %b expected 1", c, s_inst_valid); end
            n_checks++; if (s_a_out !== 64'h1010) begin n_errors++; $display("FAIL stall_a_out%0d: got %h expected 1010", c, s_a_out); end
            n_checks++; if (s_inst_out !== mem_word(64'h1010)) begin n_errors++; $display("FAIL stall_inst%0d: got %h expected %h", c, s_inst_out, mem_word(64'h1010)); end
        end
        n_checks++; if (req_q.size() - n0 !== 2) begin n_errors++; $display("FAIL stall_req_credit: got %0d expected 2", req_q.size() - n0); end
        n_checks++; if (s_req_valid !== 1'b0) begin n_errors++; $display("FAIL stall_full_no_req: got %b expected 0", s_req_valid); end
        stall = 1'b0;
        repeat (12) cyc();
        n_checks++; if (pop_a_q.size() !== 16) begin n_errors++; $display("FAIL stall_pop_count: got %0d expected 16", pop_a_q.size()); end
        for (int i = 0; i < 16; i++) begin
            got_a = (i < pop_a_q.size()) ? pop_a_q[i] : '1;
            got_d = (i < pop_d_q.size()) ? pop_d_q[i] : '1;
            n_checks++; if (got_a !== 64'h1000 + 64'(4*i)) begin n_errors++; $display("FAIL stall_seq_a%0d: got %h expected %h", i, got_a, 64'h1000 + 64'(4*i)); end
            n_checks++; if (got_d !== mem_word(64'h1000 + 64'(4*i))) begin n_errors++; $display("FAIL stall_seq_d%0d: got %h expected %h", i, got_d, mem_word(64'h1000 + 64'(4*i))); end
        end
    endtask

    task automatic test_redirect();
        logic [63:0] got_a;
        do_reset();
        mem_hold = 1'b1;
        repeat (2) cyc();
        redirect_valid = 1'b1; redirect_pc = 64'h2000;
        cyc();
        n_checks++; if (s_req_valid !== 1'b0) begin n_errors++; $display("FAIL redir_no_req: got %b expected 0", s_req_valid); end
        n_checks++; if (s_flush !== 1'b0) begin n_errors++; $display("FAIL redir_flush_n: got %b expected 0", s_flush); end
        redirect_valid = 1'b0; mem_hold = 1'b0;
        cyc();
        n_checks++; if (s_flush !== 1'b1) begin n_errors++; $display("FAIL redir_flush_n1: got %b expected 1", s_flush); end
        n_checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 64'h2000) begin n_errors++; $display("FAIL redir_new_req: got %b/%h expected 1/2000", s_req_valid, s_req_addr); end
        cyc();
        n_checks++; if (s_flush !== 1'b0) begin n_errors++; $display("FAIL redir_flush_n2: got %b expected 0", s_flush); end
        n_checks++; if (s_inst_valid !== 1'b0) begin n_errors++; $display("FAIL redir_stale_visible: got %b expected 0", s_inst_valid); end
        repeat (5) cyc();
        for (int i = 0; i < 3; i++) begin
            got_a = (i < pop_a_q.size()) ? pop_a_q[i] : '1;
            n_checks++; if (got_a !== 64'h2000 + 64'(4*i)) begin n_errors++; $display("FAIL redir_pop_a%0d: got %h expected %h", i, got_a, 64'h2000 + 64'(4*i)); end
        end
    endtask

    task automatic test_rsp_redirect();
        do_reset();
        mem_hold = 1'b1;
        repeat (2) cyc();
        mem_hold = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h3000;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        n_checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 64'h3000) begin n_errors++; $display("FAIL rspredir_req: got %b/%h expected 1/3000", s_req_valid, s_req_addr); end
        n_checks++; if (s_inst_valid !== 1'b0) begin n_errors++; $display("FAIL rspredir_empty1: got %b expected 0", s_inst_valid); end
        cyc();
        n_checks++; if (s_inst_valid !== 1'b0) begin n_errors++; $display("FAIL rspredir_empty2: got %b expected 0", s_inst_valid); end
        cyc();
        n_checks++; if (s_inst_valid !== 1'b1) begin n_errors++; $display("FAIL rspredir_valid: got %b expected 1", s_inst_valid); end
        n_checks++; if (s_a_out !== 64'h3000) begin n_errors++; $display("FAIL rspredir_a_out: got %h expected 3000", s_a_out); end
        n_checks++; if (s_inst_out !== mem_word(64'h3000)) begin n_errors++; $display("FAIL rspredir_inst: got %h expected %h", s_inst_out, mem_word(64'h3000)); end
    endtask

    task automatic test_ready_low();
        do_reset();
        imem_req_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            n_checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 64'h1000) begin n_errors++; $display("FAIL rdylow_hold%0d: got %b/%h expected 1/1000", c, s_req_valid, s_req_addr); end
        end
        imem_req_ready = 1'b1;
        cyc();
        n_checks++; if (s_req_addr !== 64'h1000) begin n_errors++; $display("FAIL rdylow_accept: got %h expected 1000", s_req_addr); end
        cyc();
        n_checks++; if (s_req_addr !== 64'h1004) begin n_errors++; $display("FAIL rdylow_advance: got %h expected 1004", s_req_addr); end
        n_checks++; if (req_q.size() !== 2) begin n_errors++; $display("FAIL rdylow_count: got %0d expected 2", req_q.size()); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        mem_hold = 1'b1;
        cyc();
        redirect_valid = 1'b1; redirect_pc = 64'h4000;
        cyc();
        redirect_pc = 64'h5000;
        cyc();
        n_checks++; if (s_flush !== 1'b1) begin n_errors++; $display("FAIL b2b_flush1: got %b expected 1", s_flush); end
        redirect_valid = 1'b0; mem_hold = 1'b0;
        cyc();
        n_checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 64'h5000) begin n_errors++; $display("FAIL b2b_req: got %b/%h expected 1/5000", s_req_valid, s_req_addr); end
        n_checks++; if (s_flush !== 1'b1) begin n_errors++; $display("FAIL b2b_flush2: got %b expected 1", s_flush); end
        cyc();
        n_checks++; if (s_flush !== 1'b0) begin n_errors++; $display("FAIL b2b_flush3: got %b expected 0", s_flush); end
        cyc();
        n_checks++; if (s_inst_valid !== 1'b1 || s_a_out !== 64'h5000) begin n_errors++; $display("FAIL b2b_first: got %b/%h expected 1/5000", s_inst_valid, s_a_out); end
    endtask

    task automatic test_wrap();
        logic [63:0] got_a;
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        n_checks++; if (s_req_addr !== 64'hFFFF_FFFF_FFFF_FFF8) begin n_errors++; $display("FAIL wrap_a0: got %h expected fffffffffffffff8", s_req_addr); end
        cyc();
        n_checks++; if (s_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_errors++; $display("FAIL wrap_a1: got %h expected fffffffffffffffc", s_req_addr); end
        cyc();
        n_checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 64'h0) begin n_errors++; $display("FAIL wrap_a2: got %b/%h expected 1/0", s_req_valid, s_req_addr); end
        repeat (3) cyc();
        got_a = (pop_a_q.size() > 2) ? pop_a_q[2] : '1;
        n_checks++; if (got_a !== 64'h0) begin n_errors++; $display("FAIL wrap_pop: got %h expected 0", got_a); end
    endtask

    task automatic test_misalign();
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 64'h2002;
        cyc();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        cyc();
        n_checks++; if (s_fault !== 1'b1) begin n_errors++; $display("FAIL mis_fault_set: got %b expected 1", s_fault); end
        n_checks++; if (s_req_valid !== 1'b0) begin n_errors++; $display("FAIL mis_halt_req: got %b expected 0", s_req_valid); end
        repeat (2) cyc();
        n_checks++; if (req_q.size() !== 0) begin n_errors++; $display("FAIL mis_halt_count: got %0d expected 0", req_q.size()); end
        redirect_valid = 1'b1; redirect_pc = 64'h3000;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        n_checks++; if (s_fault !== 1'b0) begin n_errors++; $display("FAIL mis_fault_clr: got %b expected 0", s_fault); end
        n_checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 64'h3000) begin n_errors++; $display("FAIL mis_resume: got %b/%h expected 1/3000", s_req_valid, s_req_addr); end
`else
        cyc();
        n_checks++; if (s_fault !== 1'b0) begin n_errors++; $display("FAIL mis_fault_tied: got %b expected 0", s_fault); end
        n_checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 64'h2000) begin n_errors++; $display("FAIL mis_align_req: got %b/%h expected 1/2000", s_req_valid, s_req_addr); end
        repeat (2) cyc();
        n_checks++; if (s_inst_valid !== 1'b1 || s_a_out !== 64'h2000) begin n_errors++; $display("FAIL mis_align_pop: got %b/%h expected 1/2000", s_inst_valid, s_a_out); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_rsp_redirect();
        test_ready_low();
        test_back_to_back();
        test_wrap();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
